sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//   Single-clock FIFO: parametrised storage plus full pointer/occupancy control.
//   Supports any DEPTH (power of two not required), registered read data with a
//   valid strobe, programmable almost-full/almost-empty levels, a synchronous flush,
//   and sticky overflow/underflow error flags.
//   Used for buffering between same-clock blocks (e.g. UART/ALU command and result paths).
// PARAMETERS
//   DATA_WIDTH  8   width of each stored word
//   DEPTH       10  number of entries, >= 2
//   AF_LEVEL    8   almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL    2   almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
//   ADDR_WIDTH  derived, $clog2(DEPTH); CNT_WIDTH derived, $clog2(DEPTH+1)
// PORTS
//   clk           in   1           single clock, rising edge
//   rst           in   1           asynchronous reset, active-low
//   wr_en         in   1           write request
//   wr_data       in   DATA_WIDTH  write word
//   rd_en         in   1           read request
//   flush         in   1           synchronous empty-the-FIFO pulse
//   clr_err       in   1           clears overflow/underflow
//   rd_data       out  DATA_WIDTH  registered read word
//   rd_valid      out  1           rd_data updated this cycle (one-cycle pulse)
//   full          out  1           count == DEPTH
//   empty         out  1           count == 0
//   almost_full   out  1           count >= AF_LEVEL
//   almost_empty  out  1           count <= AE_LEVEL
//   count         out  CNT_WIDTH   current occupancy, 0..DEPTH
//   overflow      out  1           sticky: write attempted while full
//   underflow     out  1           sticky: read attempted while empty
// BEHAVIOUR
//   - Reset: rst low asynchronously sets wr_ptr=rd_ptr=0, count=0, rd_data=0,
//     rd_valid=0, overflow=0, underflow=0, so empty=1, full=0, almost_empty=1,
//     almost_full=0. Memory array is not reset.
//   - Flags are decoded combinationally from the count register; they change only on clk edges.
//   - Write is accepted when wr_en & ~full: mem[wr_ptr] <= wr_data; wr_ptr advances.
//   - Read is accepted when rd_en & ~empty: rd_data <= mem[rd_ptr]; rd_ptr advances.
//     rd_valid=1 in the following cycle only. rd_data holds its value when no read occurs.
//   - Pointer wrap: a pointer at DEPTH-1 advances to 0. Explicit compare; no
//     power-of-two wrap.
//   - Full/empty are evaluated on the pre-edge count:
//     at full, wr_en is rejected even with a simultaneous rd_en; at empty, rd_en is
//     rejected even with a simultaneous wr_en. There is no write-to-read bypass.
//   - Count: +1 on write only, -1 on read only, unchanged when both are accepted.
//   - overflow <= 1 on wr_en & full; underflow <= 1 on rd_en & empty.
//     clr_err clears both flags. A set in the same cycle wins over clr_err.
//   - flush (highest synchronous priority): ptrs=0, count=0, rd_valid=0; wr_en/rd_en
//     that cycle are ignored and raise no error flags; rd_data is held.
//   - An accepted wr or rd never corrupts the other pointer; data order is strictly FIFO.
// TESTING (DATA_WIDTH=8, DEPTH=10, AF_LEVEL=8, AE_LEVEL=2)
//   1 Reset mid-fill: drop rst at count=4 -> immediately count=0, empty=1, rd_valid=0.
//     After release, the next write/read returns the new data.
//   2 Fill: write 0x01..0x0A -> almost_full rises at count=8 and full at 10.
//     11th write of 0xFF is dropped and overflow=1. Read 10 -> 0x01..0x0A in order,
//     with rd_valid 1 cycle after each rd_en.
//   3 Wrap: write 6 words, read 6, then write 0x10..0x19 and read all ->
//     0x10..0x19 in order. wr_ptr passes 9->0.
//   4 Simultaneous: at count=5, wr+rd -> count stays 5. At full, wr+rd -> read
//     accepted, count=9, overflow=1. At empty, wr+rd -> count=1, underflow=1,
//     rd_valid=0.
//   5 Flush with wr_en=1 at count=7 -> next cycle count=0, empty=1, no error flags;
//     a following read is rejected and sets underflow.
//   6 clr_err alone -> both flags clear. clr_err with wr_en at full -> overflow stays 1.

Source files
------------

// File: rtl/sync_fifo_if.sv
// Handshake/status bundle between a single-clock FIFO and its producer/consumer.
// The FIFO uses the slave modport; the block that drives it uses master.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 10
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  flush;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_WIDTH-1:0]  count;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  wr_en, wr_data, rd_en, flush, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport master (
    output wr_en, wr_data, rd_en, flush, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO of arbitrary depth with registered read data, programmable
// almost-full/almost-empty levels, synchronous flush and sticky error flags.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 10,
  parameter int AF_LEVEL   = 8,
  parameter int AE_LEVEL   = 2
) (
  input  logic        clk,
  input  logic        rst,
  sync_fifo_if.slave  bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0]  count_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  full_w;
  logic                  empty_w;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_set;
  logic                  udf_set;

  // Explicit wrap so non-power-of-two depths never address past the array.
  function automatic logic [ADDR_WIDTH-1:0] ptr_next(input logic [ADDR_WIDTH-1:0] p);
    return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_w  = (count_r == CNT_WIDTH'(DEPTH));
  assign empty_w = (count_r == '0);

  // Flush overrides both requests, so it also suppresses error reporting.
  assign wr_acc  = bus.wr_en & ~full_w  & ~bus.flush;
  assign rd_acc  = bus.rd_en & ~empty_w & ~bus.flush;
  assign ovf_set = bus.wr_en &  full_w  & ~bus.flush;
  assign udf_set = bus.rd_en &  empty_w & ~bus.flush;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
      if (rd_acc) begin
        rd_ptr    <= ptr_next(rd_ptr);
        rd_data_r <= mem[rd_ptr];
      end
      rd_valid_r <= rd_acc;
      case ({wr_acc, rd_acc})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // A new error event in the same cycle takes precedence over clearing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (ovf_set)          overflow_r  <= 1'b1;
      else if (bus.clr_err) overflow_r  <= 1'b0;
      if (udf_set)          underflow_r <= 1'b1;
      else if (bus.clr_err) underflow_r <= 1'b0;
    end
  end

  assign bus.rd_data      = rd_data_r;
  assign bus.rd_valid     = rd_valid_r;
  assign bus.count        = count_r;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_r >= CNT_WIDTH'(AF_LEVEL));
  assign bus.almost_empty = (count_r <= CNT_WIDTH'(AE_LEVEL));
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_sync_fifo.sv
// Randomised scoreboard bench for sync_fifo: a queue-based reference model predicts
// occupancy, flags and read data; a negedge monitor pops expected read words.
module tb_sync_fifo;
  localparam int DW  = 8;
  localparam int DEP = 10;
  localparam int AF  = 8;
  localparam int AE  = 2;

  logic clk;
  logic rst_n;

  sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEP)) bus ();

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  bit m_ovf, m_udf, m_vld;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_state();
    int n = model_q.size();
    check("count",        int'(bus.count),        n);
    check("full",         int'(bus.full),         int'(n == DEP));
    check("empty",        int'(bus.empty),        int'(n == 0));
    check("almost_full",  int'(bus.almost_full),  int'(n >= AF));
    check("almost_empty", int'(bus.almost_empty), int'(n <= AE));
    check("overflow",     int'(bus.overflow),     int'(m_ovf));
    check("underflow",    int'(bus.underflow),    int'(m_udf));
    check("rd_valid",     int'(bus.rd_valid),     int'(m_vld));
  endtask

  // One clock of stimulus; the model is advanced from the pre-edge occupancy.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r,
                      input bit fl, input bit ce);
    int n = model_q.size();
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    bus.flush   = fl;
    bus.clr_err = ce;
    if (fl) begin
      model_q.delete();
      m_vld = 0;
      if (ce) begin m_ovf = 0; m_udf = 0; end
    end else begin
      m_vld = r && (n > 0);
      if (m_vld) exp_q.push_back(model_q.pop_front());
      if (w && n < DEP) model_q.push_back(d);
      if (w && n == DEP) m_ovf = 1; else if (ce) m_ovf = 0;
      if (r && n == 0)   m_udf = 1; else if (ce) m_udf = 0;
    end
    @(posedge clk);
    #1;
    bus.wr_en = 0; bus.rd_en = 0; bus.flush = 0; bus.clr_err = 0;
    check_state();
  endtask

  task automatic wr(input logic [DW-1:0] d); step(1, d, 0, 0, 0); endtask
  task automatic rd();                       step(0, '0, 1, 0, 0); endtask
  task automatic idle();                     step(0, '0, 0, 0, 0); endtask

  always @(negedge clk) begin
    if (rst_n && bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rd_unexpected: got data %0h expected no read", bus.rd_data);
      end else begin
        check("rd_data", int'(bus.rd_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.wr_en = 0; bus.wr_data = '0; bus.rd_en = 0; bus.flush = 0; bus.clr_err = 0;
    m_ovf = 0; m_udf = 0; m_vld = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_state();
    check("rst_rd_data", int'(bus.rd_data), 0);
    @(negedge clk);
    rst_n = 1;

    // Reset mid-fill: asynchronous, visible before the next edge
    for (int i = 0; i < 4; i++) wr(DW'(8'h30 + i));
    #2 rst_n = 0;
    #1;
    model_q.delete(); exp_q.delete(); m_ovf = 0; m_udf = 0; m_vld = 0;
    check("async_rst_count",    int'(bus.count),    0);
    check("async_rst_empty",    int'(bus.empty),    1);
    check("async_rst_rd_valid", int'(bus.rd_valid), 0);
    @(negedge clk);
    rst_n = 1;
    wr(8'hA5); rd(); idle();

    // Fill to full, reject the extra write, drain in order
    for (int i = 1; i <= 10; i++) wr(DW'(i));
    wr(8'hFF);
    for (int i = 0; i < 10; i++) rd();
    idle();
    step(0, '0, 0, 0, 1);

    // Pointer wrap past the last entry
    for (int i = 0; i < 6; i++) wr(DW'($urandom));
    for (int i = 0; i < 6; i++) rd();
    for (int i = 0; i < 10; i++) wr(DW'(8'h10 + i));
    for (int i = 0; i < 10; i++) rd();
    idle();

    // Simultaneous read and write at mid, full and empty
    for (int i = 0; i < 5; i++) wr(DW'(8'h40 + i));
    step(1, 8'h45, 1, 0, 0);
    for (int i = 0; i < 5; i++) wr(DW'(8'h50 + i));
    step(1, 8'h66, 1, 0, 0);
    for (int i = 0; i < 9; i++) rd();
    step(1, 8'h77, 1, 0, 0);
    rd(); idle();
    step(0, '0, 0, 0, 1);

    // Flush overrides a concurrent write; following read underflows
    for (int i = 0; i < 7; i++) wr(DW'(8'h80 + i));
    step(1, 8'hEE, 0, 1, 0);
    rd(); idle();

    // clr_err alone, then clr_err racing a fresh overflow
    step(0, '0, 0, 0, 1);
    for (int i = 0; i < 10; i++) wr(DW'(8'h90 + i));
    step(1, 8'hAB, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    for (int i = 0; i < 10; i++) rd();
    idle();

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6);
    idle(); idle();
    check("sb_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
